// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace checker.
// Holds the checker state enum, error codes and the golden-trace entry layout.
package wb_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FAIL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_MISMATCH  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    // 69-bit golden commit record
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_entry_t;

    // Expand per-byte write enables into a 32-bit data mask
    function automatic logic [31:0] wen_mask(input logic [3:0] wen);
        return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    endfunction

endpackage

// File: rtl/wb_trace_checker_fifo.sv
// Synchronous FIFO holding golden-trace entries for wb_trace_checker.
// DEPTH must be a power of two so the pointers wrap naturally.
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  trace_entry_t data_i,
    output trace_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    trace_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Pointer/count registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array, written on accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares CPU writeback commits against a pushed golden trace.
// Optional macro WB_TIMEOUT_EN adds an idle-cycle timeout error.
module wb_trace_checker
    import wb_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] END_PC      = 32'hbfc0_0100,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_wen,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        trace_valid,
    output logic        trace_ready,
    input  logic [31:0] trace_pc,
    input  logic [4:0]  trace_wnum,
    input  logic [31:0] trace_wdata,
    output logic [31:0] pass_cnt,
    output logic        done,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] err_got_wdata
);

    state_e       state_q, state_d;
    logic [31:0]  pass_q, pass_d;
    logic [1:0]   code_q, code_d;
    logic [31:0]  epc_q, epc_d;
    logic [31:0]  eexp_q, eexp_d;
    logic [31:0]  egot_q, egot_d;

    trace_entry_t head, push_ent;
    logic         fifo_full, fifo_empty;
    logic         pop, commit, match;
    logic         err;
    logic [1:0]   err_kind;
    logic [31:0]  exp_w;

`ifdef WB_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;
    logic [31:0]  idle_q, idle_d;
`else
    logic         unused_tmo;
    assign unused_tmo = ^(32'(TIMEOUT_CYC));
`endif

    assign commit   = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign trace_ready = resetn && !fifo_full && (state_q == ST_RUN);
    assign push_ent = '{pc: trace_pc, wnum: trace_wnum, wdata: trace_wdata};

    assign match = (head.pc == debug_wb_pc)
                && (head.wnum == debug_wb_rf_wnum)
                && (((head.wdata ^ debug_wb_rf_wdata)
                     & wen_mask(debug_wb_rf_wen)) == 32'd0);

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (trace_valid && trace_ready),
        .pop_i   (pop),
        .data_i  (push_ent),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Compare, error capture and RUN/FAIL/DONE transitions
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        code_d   = code_q;
        epc_d    = epc_q;
        eexp_d   = eexp_q;
        egot_d   = egot_q;
        pop      = 1'b0;
        err      = 1'b0;
        err_kind = ERR_NONE;
        exp_w    = 32'd0;
`ifdef WB_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        if (state_q == ST_RUN) begin
            if (commit) begin
                if (fifo_empty) begin
                    err      = 1'b1;
                    err_kind = ERR_UNDERFLOW;
                end else begin
                    pop = 1'b1;
                    if (match) begin
                        if (pass_q != 32'hffff_ffff) pass_d = pass_q + 32'd1;
                    end else begin
                        err      = 1'b1;
                        err_kind = ERR_MISMATCH;
                        exp_w    = head.wdata;
                    end
                end
            end
`ifdef WB_TIMEOUT_EN
            if (commit) begin
                idle_d = 32'd0;
            end else begin
                idle_d = idle_q + 32'd1;
                if (idle_q == TMO_LAST) begin
                    err      = 1'b1;
                    err_kind = ERR_TIMEOUT;
                end
            end
`endif
            if (err) begin
                state_d = ST_FAIL;
                code_d  = err_kind;
                epc_d   = debug_wb_pc;
                eexp_d  = exp_w;
                egot_d  = (err_kind == ERR_TIMEOUT) ? 32'd0
                                                    : debug_wb_rf_wdata;
            end else if (debug_wb_pc == END_PC) begin
                state_d = ST_DONE;
            end
        end
    end

    // Checker state and capture registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            pass_q  <= 32'd0;
            code_q  <= ERR_NONE;
            epc_q   <= 32'd0;
            eexp_q  <= 32'd0;
            egot_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            eexp_q  <= eexp_d;
            egot_q  <= egot_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Idle-cycle counter between commits
    always_ff @(posedge clk) begin
        if (!resetn) idle_q <= 32'd0;
        else         idle_q <= idle_d;
    end
`endif

    assign pass_cnt      = pass_q;
    assign done          = (state_q == ST_DONE);
    assign fail          = (state_q == ST_FAIL);
    assign err_code      = code_q;
    assign err_pc        = epc_q;
    assign err_exp_wdata = eexp_q;
    assign err_got_wdata = egot_q;

endmodule

// File: doc/wb_trace_checker.md
WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the golden-trace buffer depth in entries, a power of two and at least 2.
REQ-002 Parameter END_PC, default 32'hbfc0_0100, is the writeback PC that ends the test.
REQ-003 Parameter TIMEOUT_CYC, default 65535, is the maximum number of idle cycles between commits.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 debug_wb_pc  in  32  PC of the instruction in writeback.
REQ-007 debug_wb_rf_wen  in  4  byte write enables of the register file.
REQ-008 debug_wb_rf_wnum  in  5  destination register number.
REQ-009 debug_wb_rf_wdata  in  32  data written to the register file.
REQ-010 trace_valid / trace_ready  in / out  1 / 1  golden-trace push handshake.
REQ-011 trace_pc, trace_wnum, trace_wdata  in  32, 5, 32  expected commit.
REQ-012 pass_cnt  out  32  number of matched commits.
REQ-013 done, fail  out  1, 1  terminal status flags.
REQ-014 err_code  out  2  failure cause: 0 none, 1 mismatch, 2 underflow, 3 timeout.
REQ-015 err_pc, err_exp_wdata, err_got_wdata  out  32 each  capture of the first failure.

Function
REQ-016 A commit is a cycle with debug_wb_rf_wen != 0 and debug_wb_rf_wnum != 0; writes to $0 are ignored.
REQ-017 A trace push occurs when trace_valid && trace_ready; trace_ready = !fifo_full && state==RUN.
REQ-018 States:
- RUN to FAIL on any error.
- RUN to DONE when debug_wb_pc == END_PC with no error in that cycle.
- FAIL and DONE are absorbing until reset.
REQ-019 On a commit in RUN with a non-empty FIFO, the checker compares the head entry and pops it in the same cycle.
REQ-020 Match condition: pc equal, wnum equal, and wdata equal on every byte whose wen bit is 1; a match increments pass_cnt by 1 in the next cycle.
REQ-021 On a mismatch: err_code=1, err_pc=debug_wb_pc, err_exp_wdata=head wdata, err_got_wdata=debug_wb_rf_wdata; the entry is popped and fail=1 from the next cycle.
REQ-022 On a commit with an empty FIFO: err_code=2, err_exp_wdata=0, captures taken as in REQ-021.
REQ-023 No bypass: a push and a commit in the same cycle on an empty FIFO is an underflow.
REQ-024 A push and a pop in the same cycle on a non-empty, non-full FIFO leave the occupancy unchanged.
REQ-025 Occupancy never exceeds FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 Error captures and err_code are written only on the RUN-to-FAIL transition, so the first error is preserved.
REQ-027 A commit and debug_wb_pc == END_PC in the same cycle: compare first; a mismatch or underflow goes to FAIL, a match goes to DONE and counts.
REQ-028 pass_cnt saturates at 32'hffff_ffff.
REQ-029 done and fail are registered outputs; done and fail are never both 1.

Reset
REQ-030 With resetn=0 at a clock edge:
- state becomes RUN and the FIFO empties;
- pass_cnt, done, fail, err_code, err_pc, err_exp_wdata, err_got_wdata and the timeout counter become 0;
- trace_ready=0 during reset and 1 in the cycle after resetn rises.
REQ-031 Reset asserted mid-test discards all buffered entries and any pending failure.

Configuration
REQ-032 Macro WB_TIMEOUT_EN, when defined, adds a 32-bit idle counter.
- The counter clears on every commit and increments each RUN cycle without a commit.
- When it reaches TIMEOUT_CYC: err_code=3, err_pc=debug_wb_pc, both wdata captures=0, state goes to FAIL.
REQ-033 Without WB_TIMEOUT_EN, the counter is absent and err_code=3 is never produced.

Structure
REQ-034 Package wb_trace_pkg holds:
- the state enum (RUN, FAIL, DONE);
- the err_code constants;
- the 69-bit trace entry struct {pc, wnum, wdata}.
REQ-035 Sub-module trace_fifo, a synchronous FIFO of FIFO_DEPTH entries with full/empty outputs, holds the golden trace; comparison and the FSM stay in wb_trace_checker.

Verification
REQ-036 Push 3 entries; commit the same 3 (pc 0xbfc00000/4/8, wnum 2, wdata 1/2/3) -> pass_cnt=3, fail=0.
REQ-037 Expected wdata 0x12345678, committed 0x12345679 at pc 0xbfc00010 -> fail=1, err_code=1, err_pc=0xbfc00010, captures correct; a later matching commit leaves pass_cnt unchanged.
REQ-038 Commit with an empty FIFO while trace_valid=1 in the same cycle -> err_code=2, fail=1.
REQ-039 Hold trace_valid=1 with no commits for 6 cycles, depth 4 -> exactly 4 pushes accepted and trace_ready=0 after the 4th.
REQ-040 Matching commit at pc END_PC -> done=1, pass_cnt incremented, trace_ready=0; then resetn=0 for 1 cycle -> all outputs 0 and trace_ready=1 the next cycle.
REQ-041 With WB_TIMEOUT_EN and TIMEOUT_CYC=16, no commits for 16 cycles -> err_code=3, fail=1.
